// File: rtl/da_wave_gen_if.sv
// Configuration handshake between a host and the waveform generator.
// A word transfers on a clock edge where cfg_valid and cfg_ready are both high.
interface da_wave_gen_if #(
  parameter int PHASE_W = 32,
  parameter int DATA_W  = 12
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [PHASE_W-1:0] cfg_freq;
  logic [1:0]         cfg_wave;
  logic [DATA_W-1:0]  cfg_amp;

  modport master (output cfg_valid, cfg_freq, cfg_wave, cfg_amp, input cfg_ready);
  modport slave  (input  cfg_valid, cfg_freq, cfg_wave, cfg_amp, output cfg_ready);
endinterface

// File: rtl/da_wave_gen.sv
// DDS waveform generator driving an offset-binary DAC: phase accumulator,
// waveform shaping, amplitude scaling, and glitch-free retune at phase wrap.
module da_wave_gen #(
  parameter int PHASE_W = 32,
  parameter int DATA_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  da_wave_gen_if.slave      cfg,
  output logic              DA_CLK,
  output logic [DATA_W-1:0] DA_OUT,
  output logic              sync
);

  localparam int STAGES = 3;
  localparam int PW     = 2*DATA_W + 2;
  localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  typedef struct packed {
    logic [PHASE_W-1:0] freq;
    logic [1:0]         wave;
    logic [DATA_W-1:0]  amp;
  } wcfg_t;

  state_t             state_q;
  logic               ready_q;
  wcfg_t              act_q, shd_q, cfg_in;
  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W:0]   sum;
  logic               running, wrap, xfer;

  assign cfg_in    = '{freq: cfg.cfg_freq, wave: cfg.cfg_wave, amp: cfg.cfg_amp};
  assign cfg.cfg_ready = ready_q;
  assign DA_CLK    = ~clk;

  assign running = (state_q != IDLE);
  assign sum     = {1'b0, phase_q} + {1'b0, act_q.freq};
  assign wrap    = running & sum[PHASE_W];
  assign xfer    = cfg.cfg_valid & ready_q;

  // Control: a word taken while running waits in the shadow set until the
  // accumulator wraps, so the new settings always start a fresh period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      act_q   <= '0;
      shd_q   <= '0;
      phase_q <= '0;
    end else begin
      phase_q <= running ? sum[PHASE_W-1:0] : '0;
      case (state_q)
        IDLE: begin
          if (xfer)   act_q   <= cfg_in;
          if (enable) state_q <= RUN;
        end
        RUN: begin
          if (!enable) state_q <= IDLE;
          else if (xfer) begin
            shd_q   <= cfg_in;
            state_q <= PEND;
            ready_q <= 1'b0;
          end
        end
        PEND: begin
          if (!enable) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end else if (wrap) begin
            act_q   <= shd_q;
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  logic [DATA_W-1:0]      p, tri_v, raw_c, raw_q, amp_q;
  logic signed [DATA_W:0] diff, amp_s;
  logic signed [PW-1:0]   prod_q;
  logic [STAGES:0]        sync_pipe;

  assign p     = phase_q[PHASE_W-1 -: DATA_W];
  assign tri_v = {p[DATA_W-2:0], 1'b0};

  always_comb begin
    raw_c = p;
    case (act_q.wave)
      2'd0:    raw_c = p[DATA_W-1] ? '0 : '1;
      2'd1:    raw_c = p;
      2'd2:    raw_c = p[DATA_W-1] ? ~tri_v : tri_v;
      default: raw_c = ~p;
    endcase
  end

  assign diff  = $signed({1'b0, raw_q}) - $signed({1'b0, MID});
  assign amp_s = $signed({1'b0, amp_q});

  // Amp travels beside its raw sample so a retune never mixes old and new.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q     <= MID;
      amp_q     <= '0;
      prod_q    <= '0;
      DA_OUT    <= MID;
      sync_pipe <= '0;
    end else begin
      raw_q     <= running ? raw_c : MID;
      amp_q     <= act_q.amp;
      prod_q    <= PW'(diff) * PW'(amp_s);
      DA_OUT    <= DATA_W'(prod_q >>> DATA_W) + MID;
      sync_pipe <= {sync_pipe[STAGES-1:0], wrap};
    end
  end

  assign sync = sync_pipe[STAGES];

endmodule

// File: tb/tb_da_wave_gen.sv
// Directed bench for da_wave_gen: reset, waveform shapes, scaling, retune
// timing, back-to-back offers and the enable/frequency boundary cases.
module tb_da_wave_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        da_clk;
  logic [11:0] da_out;
  logic        sync;

  int cyc   = 0;
  int n_chk = 0;
  int n_bad = 0;
  int n_sync, n_hi;

  da_wave_gen_if #(.PHASE_W(32), .DATA_W(12)) cfg_if ();

  da_wave_gen #(.PHASE_W(32), .DATA_W(12)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .cfg    (cfg_if),
    .DA_CLK (da_clk),
    .DA_OUT (da_out),
    .sync   (sync)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d want %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick(1);
  endtask

  task automatic offer(input logic [31:0] f, input logic [1:0] w, input logic [11:0] a);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_freq  = f;
    cfg_if.cfg_wave  = w;
    cfg_if.cfg_amp   = a;
  endtask

  // Park, load a word while idle, then enable; cyc=0 right after the edge
  // that moves the FSM to RUN (phase still 0 there).
  task automatic start(input logic [31:0] f, input logic [1:0] w, input logic [11:0] a);
    enable = 1'b0;
    tick(4);
    offer(f, w, a);
    tick(1);
    cfg_if.cfg_valid = 1'b0;
    enable = 1'b1;
    tick(1);
    cyc = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_freq = '0;
    cfg_if.cfg_wave = '0;
    cfg_if.cfg_amp = '0;
    tick(2);
    chk("rst_out",   32'(da_out), 2048);
    chk("rst_sync",  32'(sync), 0);
    chk("rst_ready", 32'(cfg_if.cfg_ready), 1);
    rst_n = 1'b1;
    tick(2);

    // Sawtooth, full amplitude
    start(32'h0010_0000, 2'd1, 12'd4095);
    n_sync = 0;
    for (int c = 1; c <= 8195; c++) begin
      tick(1);
      if (sync) n_sync++;
      case (cyc)
        2:    chk("saw_lat",  32'(da_out), 2048);
        3:    begin chk("saw_0", 32'(da_out), 0); chk("saw_0_sync", 32'(sync), 0); end
        4:    chk("saw_1",    32'(da_out), 1);
        103:  chk("saw_100",  32'(da_out), 100);
        2051: chk("saw_2048", 32'(da_out), 2048);
        2052: chk("saw_2049", 32'(da_out), 2048);
        3003: chk("saw_3000", 32'(da_out), 2999);
        4098: begin chk("saw_4095", 32'(da_out), 4094); chk("saw_4095_sync", 32'(sync), 0); end
        4099: begin chk("saw_wrap", 32'(da_out), 0); chk("saw_wrap_sync", 32'(sync), 1); end
        4100: chk("saw_wrap1", 32'(da_out), 1);
        default: ;
      endcase
    end
    chk("saw_nsync", 32'(n_sync), 2);

    // Square, half amplitude
    start(32'h0010_0000, 2'd0, 12'd2048);
    n_hi = 0;
    for (int c = 1; c <= 4099; c++) begin
      tick(1);
      if (cyc >= 3 && cyc <= 4098 && da_out == 12'd3071) n_hi++;
      case (cyc)
        3:    chk("sq_hi0",  32'(da_out), 3071);
        2050: chk("sq_hi1",  32'(da_out), 3071);
        2051: chk("sq_lo0",  32'(da_out), 1024);
        4098: chk("sq_lo1",  32'(da_out), 1024);
        4099: begin chk("sq_wrap", 32'(da_out), 3071); chk("sq_sync", 32'(sync), 1); end
        default: ;
      endcase
    end
    chk("sq_nhi", 32'(n_hi), 2048);

    // Triangle and inverted sawtooth spot values
    start(32'h0010_0000, 2'd2, 12'd4095);
    run_to(3);    chk("tri_0",    32'(da_out), 0);
    run_to(4);    chk("tri_1",    32'(da_out), 2);
    run_to(1027); chk("tri_1024", 32'(da_out), 2048);
    run_to(2050); chk("tri_2047", 32'(da_out), 4093);
    run_to(2051); chk("tri_2048", 32'(da_out), 4094);
    run_to(3003); chk("tri_3000", 32'(da_out), 2190);
    start(32'h0010_0000, 2'd3, 12'd4095);
    run_to(3);    chk("isaw_0",   32'(da_out), 4094);
    run_to(8);    chk("isaw_5",   32'(da_out), 4089);

    // Glitch-free retune: new rate starts exactly at the wrap
    start(32'h0010_0000, 2'd1, 12'd4095);
    run_to(1000);
    offer(32'h0020_0000, 2'd1, 12'd4095);
    tick(1);
    chk("rt_ready_lo", 32'(cfg_if.cfg_ready), 0);
    cfg_if.cfg_valid = 1'b0;
    run_to(4095); chk("rt_ready_pre",  32'(cfg_if.cfg_ready), 0);
    run_to(4096); chk("rt_ready_wrap", 32'(cfg_if.cfg_ready), 1);
    run_to(4098); chk("rt_last_old",   32'(da_out), 4094);
    run_to(4099); chk("rt_first_new",  32'(da_out), 0); chk("rt_sync", 32'(sync), 1);
    run_to(4100); chk("rt_step2",      32'(da_out), 2);
    run_to(4101); chk("rt_step4",      32'(da_out), 4);
    run_to(6147); chk("rt_wrap2",      32'(da_out), 0); chk("rt_wrap2_sync", 32'(sync), 1);

    // Back-to-back offers with cfg_valid held high
    start(32'h0010_0000, 2'd1, 12'd4095);
    run_to(10);
    offer(32'h0020_0000, 2'd1, 12'd4095);
    tick(1);
    chk("b2b_acc_a", 32'(cfg_if.cfg_ready), 0);
    cfg_if.cfg_freq = 32'h0040_0000;
    run_to(4095); chk("b2b_hold",  32'(cfg_if.cfg_ready), 0);
    run_to(4096); chk("b2b_wrap",  32'(cfg_if.cfg_ready), 1);
    run_to(4097); chk("b2b_acc_b", 32'(cfg_if.cfg_ready), 0);
    cfg_if.cfg_valid = 1'b0;
    run_to(4101); chk("b2b_rate_a", 32'(da_out), 4);
    run_to(6143); chk("b2b_hold2",  32'(cfg_if.cfg_ready), 0);
    run_to(6144); chk("b2b_wrap2",  32'(cfg_if.cfg_ready), 1);
    run_to(6147); chk("b2b_sync2",  32'(sync), 1);
    run_to(6148); chk("b2b_rate_b", 32'(da_out), 4);

    // Zero amplitude parks at midscale whatever the wave
    start(32'h0100_0000, 2'd2, 12'd0);
    for (int c = 1; c <= 16; c++) begin
      tick(1);
      chk("amp0", 32'(da_out), 2048);
    end

    // Zero frequency: pending word never applies; enable low discards it
    start(32'h0000_0000, 2'd1, 12'd4095);
    tick(5);
    chk("f0_out", 32'(da_out), 0);
    offer(32'h0010_0000, 2'd1, 12'd4095);
    tick(1);
    cfg_if.cfg_valid = 1'b0;
    chk("f0_pend", 32'(cfg_if.cfg_ready), 0);
    tick(50);
    chk("f0_still_pend", 32'(cfg_if.cfg_ready), 0);
    chk("f0_still_out",  32'(da_out), 0);
    enable = 1'b0;
    tick(1);
    chk("f0_idle_ready", 32'(cfg_if.cfg_ready), 1);
    tick(3);
    chk("f0_park", 32'(da_out), 2048);
    enable = 1'b1;
    tick(10);
    chk("f0_discard", 32'(da_out), 0);

    // Asynchronous reset while a word is pending
    start(32'h0010_0000, 2'd1, 12'd4095);
    tick(10);
    offer(32'h0020_0000, 2'd1, 12'd4095);
    tick(1);
    cfg_if.cfg_valid = 1'b0;
    chk("ar_pend", 32'(cfg_if.cfg_ready), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out",   32'(da_out), 2048);
    chk("ar_sync",  32'(sync), 0);
    chk("ar_ready", 32'(cfg_if.cfg_ready), 1);
    tick(2);
    rst_n = 1'b1;
    tick(6);
    chk("ar_post_out",   32'(da_out), 2048);
    chk("ar_post_ready", 32'(cfg_if.cfg_ready), 1);
    enable = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
